// File: rtl/udp_ddr_pkg.sv
// Shared types and constants for the UDP stream to DDR ring writer.
// State encoding, segment record and AXI field constants.
package udp_ddr_pkg;

    typedef enum logic [1:0] {
        IDLE,
        AW,
        W,
        B
    } state_t;

    // One closed input segment: beat count (1..256) and packet-end flag.
    typedef struct packed {
        logic [8:0] len;
        logic       last;
    } seg_t;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

    function automatic logic [2:0] axi_size(int bytes);
        return 3'($clog2(bytes));
    endfunction

endpackage

// File: rtl/udp_stream_ddr_writer_if.sv
// Stream-in / AXI4-write-out bundle of the DDR ring writer.
// master: writer side (stream slave, AXI master); slave: environment side.
interface udp_stream_ddr_writer_if #(
    parameter int DSIZE  = 128,
    parameter int ASIZE  = 32,
    parameter int IDSIZE = 4
) ();

    logic [DSIZE-1:0]   s_tdata;
    logic               s_tvalid;
    logic               s_tlast;
    logic               s_tready;

    logic [IDSIZE-1:0]  m_awid;
    logic [ASIZE-1:0]   m_awaddr;
    logic [7:0]         m_awlen;
    logic [2:0]         m_awsize;
    logic [1:0]         m_awburst;
    logic               m_awvalid;
    logic               m_awready;

    logic [DSIZE-1:0]   m_wdata;
    logic [DSIZE/8-1:0] m_wstrb;
    logic               m_wlast;
    logic               m_wvalid;
    logic               m_wready;

    logic [IDSIZE-1:0]  m_bid;
    logic [1:0]         m_bresp;
    logic               m_bvalid;
    logic               m_bready;

    modport master (
        input  s_tdata, s_tvalid, s_tlast,
        output s_tready,
        output m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        input  m_awready,
        output m_wdata, m_wstrb, m_wlast, m_wvalid,
        input  m_wready,
        input  m_bid, m_bresp, m_bvalid,
        output m_bready
    );

    modport slave (
        output s_tdata, s_tvalid, s_tlast,
        input  s_tready,
        input  m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awvalid,
        output m_awready,
        input  m_wdata, m_wstrb, m_wlast, m_wvalid,
        output m_wready,
        output m_bid, m_bresp, m_bvalid,
        input  m_bready
    );

endinterface

// File: rtl/udp_ddr_sync_fifo.sv
// Single-clock first-word-fall-through FIFO.
// Ports: clock/rst, wr_en/wr_data/full, rd_en/rd_data/empty.
module udp_ddr_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    output logic             full,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [PW:0]      count;
    logic             do_wr;
    logic             do_rd;

    // A write into a full FIFO is accepted when a read frees a slot
    // in the same cycle.
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign full    = (count == (PW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign rd_data = mem[rd_ptr];

    function automatic logic [PW-1:0] inc(logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= inc(wr_ptr);
            end
            if (do_rd) begin
                rd_ptr <= inc(rd_ptr);
            end
            count <= count + (PW+1)'(do_wr) - (PW+1)'(do_rd);
        end
    end

endmodule

// File: rtl/udp_stream_ddr_writer.sv
// Writes the UDP payload stream into a DDR ring, one AXI4 burst per slot.
// Ports: clock, rst, bus (stream in + AXI write out), burst/packet pulses,
// wr_slot (next slot to issue), bresp_err (sticky write error).
module udp_stream_ddr_writer
    import udp_ddr_pkg::*;
#(
    parameter int               DSIZE     = 128,
    parameter int               ASIZE     = 32,
    parameter int               IDSIZE    = 4,
    parameter int               BURST_LEN = 16,
    parameter logic [ASIZE-1:0] BASE_ADDR = '0,
    parameter int               SLOTS     = 1024,
    parameter int               SEG_DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     rst,
    udp_stream_ddr_writer_if.master  bus,
    output logic                     burst_done,
    output logic                     pkt_done,
    output logic [$clog2(SLOTS)-1:0] wr_slot,
    output logic                     bresp_err
);

    localparam int SW         = $clog2(SLOTS);
    localparam int BEAT_BYTES = DSIZE / 8;
    localparam int SLOT_SHIFT = $clog2(BURST_LEN * BEAT_BYTES);
    localparam int DDEPTH     = SEG_DEPTH * BURST_LEN;

    state_t     state;
    seg_t       cur;
    seg_t       seg_in;
    seg_t       seg_out;
    logic [8:0] beat_cnt;
    logic [8:0] beat_next;
    logic [8:0] w_cnt;
    logic       in_fire;
    logic       seg_close;
    logic       seg_pop;
    logic       seg_full;
    logic       seg_empty;
    logic       dat_full;
    logic       dat_empty;
    logic       w_fire;
    logic       unused_bid;

    assign unused_bid = ^bus.m_bid;

    // Input segmenter: a segment ends on tlast or on the BURST_LEN-th beat.
    assign in_fire   = bus.s_tvalid && bus.s_tready;
    assign beat_next = beat_cnt + 9'd1;
    assign seg_close = in_fire &&
                       (bus.s_tlast || beat_next == 9'(BURST_LEN));
    assign seg_in    = '{len: beat_next, last: bus.s_tlast};

    // The FSM pops in IDLE, so a full queue still takes this cycle's push.
    assign seg_pop      = (state == IDLE) && !seg_empty;
    assign bus.s_tready = !rst && !dat_full && (!seg_full || seg_pop);

    always_ff @(posedge clock) begin
        if (rst) begin
            beat_cnt <= '0;
        end else if (in_fire) begin
            beat_cnt <= seg_close ? 9'd0 : beat_next;
        end
    end

    udp_ddr_sync_fifo #(
        .WIDTH (DSIZE),
        .DEPTH (DDEPTH)
    ) u_data_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (in_fire),
        .wr_data (bus.s_tdata),
        .full    (dat_full),
        .rd_en   (w_fire),
        .rd_data (bus.m_wdata),
        .empty   (dat_empty)
    );

    udp_ddr_sync_fifo #(
        .WIDTH ($bits(seg_t)),
        .DEPTH (SEG_DEPTH)
    ) u_seg_fifo (
        .clock   (clock),
        .rst     (rst),
        .wr_en   (seg_close),
        .wr_data (seg_in),
        .full    (seg_full),
        .rd_en   (seg_pop),
        .rd_data (seg_out),
        .empty   (seg_empty)
    );

    assign bus.m_awid    = IDSIZE'(0);
    assign bus.m_awsize  = axi_size(BEAT_BYTES);
    assign bus.m_awburst = AXI_BURST_INCR;
    assign bus.m_wstrb   = '1;

    // W data comes straight from the FIFO head, so it is held until taken.
    assign bus.m_wvalid = (state == W) && !dat_empty;
    assign bus.m_wlast  = (state == W) && (w_cnt == cur.len - 9'd1);
    assign w_fire       = bus.m_wvalid && bus.m_wready;

    always_ff @(posedge clock) begin
        if (rst) begin
            state         <= IDLE;
            cur           <= '0;
            w_cnt         <= '0;
            bus.m_awaddr  <= '0;
            bus.m_awlen   <= '0;
            bus.m_awvalid <= 1'b0;
            bus.m_bready  <= 1'b0;
            burst_done    <= 1'b0;
            pkt_done      <= 1'b0;
            wr_slot       <= '0;
            bresp_err     <= 1'b0;
        end else begin
            burst_done <= 1'b0;
            pkt_done   <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (!seg_empty) begin
                        cur           <= seg_out;
                        // Every burst owns a whole slot, even if short.
                        bus.m_awaddr  <= BASE_ADDR +
                                         (ASIZE'(wr_slot) << SLOT_SHIFT);
                        bus.m_awlen   <= 8'(seg_out.len - 9'd1);
                        bus.m_awvalid <= 1'b1;
                        state         <= AW;
                    end
                end
                AW: begin
                    if (bus.m_awready) begin
                        bus.m_awvalid <= 1'b0;
                        w_cnt         <= '0;
                        state         <= W;
                    end
                end
                W: begin
                    if (w_fire) begin
                        w_cnt <= w_cnt + 9'd1;
                        if (bus.m_wlast) begin
                            bus.m_bready <= 1'b1;
                            state        <= B;
                        end
                    end
                end
                B: begin
                    if (bus.m_bvalid) begin
                        bus.m_bready <= 1'b0;
                        burst_done   <= 1'b1;
                        pkt_done     <= cur.last;
                        // Errors are recorded, never retried.
                        wr_slot      <= wr_slot + SW'(1);
                        if (bus.m_bresp != AXI_RESP_OKAY) begin
                            bresp_err <= 1'b1;
                        end
                        state        <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_stream_ddr_writer.sv
// Directed bench for udp_stream_ddr_writer with an AXI write responder.
// Ports: none; drives the DUT through the shared interface.
module tb_udp_stream_ddr_writer;

    localparam int          DSIZE  = 128;
    localparam int          ASIZE  = 32;
    localparam int          IDSIZE = 4;
    localparam logic [31:0] BASE   = 32'h8000_0000;
    localparam int          SLOTB  = 256;

    logic       clock = 1'b0;
    logic       rst = 1'b1;
    logic       burst_done;
    logic       pkt_done;
    logic [1:0] wr_slot;
    logic       bresp_err;

    udp_stream_ddr_writer_if #(
        .DSIZE(DSIZE), .ASIZE(ASIZE), .IDSIZE(IDSIZE)
    ) bus ();

    udp_stream_ddr_writer #(
        .DSIZE     (DSIZE),
        .ASIZE     (ASIZE),
        .IDSIZE    (IDSIZE),
        .BURST_LEN (16),
        .BASE_ADDR (BASE),
        .SLOTS     (4),
        .SEG_DEPTH (4)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .bus        (bus),
        .burst_done (burst_done),
        .pkt_done   (pkt_done),
        .wr_slot    (wr_slot),
        .bresp_err  (bresp_err)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;
    int timeouts = 0;

    bit aw_hold = 1'b0;
    int aw_delay = 0;
    bit w_toggle = 1'b0;
    bit w_stall = 1'b0;
    int err_burst = -1;

    int aw_wait = 0;
    int b_issued = 0;
    int b_acked = 0;
    int wlast_seen = 0;
    int b_seen = 0;
    int w_early = 0;
    int stray_pd = 0;
    bit aw_open = 1'b0;

    logic [31:0]    aw_addr_q[$];
    logic [7:0]     aw_len_q[$];
    logic [127:0]   w_data_q[$];
    bit             w_last_q[$];
    bit             pd_q[$];

    function automatic logic [127:0] mk(int k);
        logic [31:0] v;
        v = 32'hC0DE_0000 + 32'(k);
        return {~v, v, v ^ 32'h5A5A_5A5A, 32'(k) << 4};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(int n);
        rst = 1'b1;
        repeat (n) tick();
        rst = 1'b0;
    endtask

    task automatic send_pkt(int n, int k0);
        for (int i = 0; i < n; i++) begin
            int t = 0;
            bus.s_tdata  = mk(k0 + i);
            bus.s_tvalid = 1'b1;
            bus.s_tlast  = (i == n - 1);
            do begin
                @(negedge clock);
                t++;
            end while (!bus.s_tready && t < 500);
            if (!bus.s_tready) timeouts++;
            tick();
        end
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
    endtask

    task automatic wait_bursts(int target);
        int t = 0;
        while (pd_q.size() < target && t < 3000) begin
            @(negedge clock);
            t++;
        end
        if (pd_q.size() < target) timeouts++;
        tick();
    endtask

    task automatic chk_aw(string tag, int idx, int slot, int len);
        chk({tag, "_addr"}, aw_addr_q[idx], BASE + 32'(slot * SLOTB));
        chk({tag, "_len"}, aw_len_q[idx], 8'(len));
    endtask

    task automatic chk_data(string tag, int w0, int k0, int n);
        int bad = 0;
        chk({tag, "_beats"}, w_data_q.size() - w0, n);
        for (int i = 0; i < n; i++) begin
            if (w_data_q[w0 + i] !== mk(k0 + i)) bad++;
        end
        chk({tag, "_order"}, bad, 0);
    endtask

    function automatic int count_lasts(int w0);
        int c = 0;
        for (int i = w0; i < w_last_q.size(); i++) c += int'(w_last_q[i]);
        return c;
    endfunction

    // AW responder: awready after aw_delay cycles of awvalid.
    initial begin
        bus.m_awready = 1'b0;
        forever begin
            tick();
            if (rst || aw_hold || !bus.m_awvalid || bus.m_awready) begin
                bus.m_awready = 1'b0;
                aw_wait = 0;
            end else if (aw_wait >= aw_delay) begin
                bus.m_awready = 1'b1;
            end else begin
                aw_wait++;
            end
        end
    end

    // W responder: always ready, toggling, or stalled.
    initial begin
        bus.m_wready = 1'b0;
        forever begin
            tick();
            if (rst || w_stall) bus.m_wready = 1'b0;
            else if (w_toggle) bus.m_wready = ~bus.m_wready;
            else bus.m_wready = 1'b1;
        end
    end

    // B responder: one response per observed wlast.
    initial begin
        bus.m_bvalid = 1'b0;
        bus.m_bresp  = 2'b00;
        bus.m_bid    = '0;
        forever begin
            tick();
            if (rst) begin
                bus.m_bvalid = 1'b0;
                b_issued = wlast_seen;
                b_acked = b_seen;
            end else begin
                if (bus.m_bvalid && b_seen > b_acked) begin
                    bus.m_bvalid = 1'b0;
                    b_acked = b_seen;
                end
                if (!bus.m_bvalid && wlast_seen > b_issued) begin
                    bus.m_bvalid = 1'b1;
                    bus.m_bresp  = (b_issued == err_burst) ? 2'b10 : 2'b00;
                    bus.m_bid    = 4'(b_issued);
                    b_issued++;
                end
            end
        end
    end

    // Monitor: sampled mid-cycle, records handshakes due at the next edge.
    initial begin
        forever begin
            @(negedge clock);
            if (rst) begin
                aw_open = 1'b0;
            end else begin
                if (bus.m_awvalid && bus.m_awready) begin
                    aw_addr_q.push_back(bus.m_awaddr);
                    aw_len_q.push_back(bus.m_awlen);
                    aw_open = 1'b1;
                end
                if (bus.m_wvalid && !aw_open) w_early++;
                if (bus.m_wvalid && bus.m_wready) begin
                    w_data_q.push_back(bus.m_wdata);
                    w_last_q.push_back(bus.m_wlast);
                    if (bus.m_wlast) begin
                        aw_open = 1'b0;
                        wlast_seen++;
                    end
                end
                if (bus.m_bvalid && bus.m_bready) b_seen++;
                if (burst_done) pd_q.push_back(pkt_done);
                if (pkt_done && !burst_done) stray_pd++;
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0;
        int w0;
        int p0;
        int acc;

        bus.s_tdata  = '0;
        bus.s_tvalid = 1'b0;
        bus.s_tlast  = 1'b0;
        rst = 1'b1;

        // Reset state
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst_tready", bus.s_tready, 0);
        chk("rst_awvalid", bus.m_awvalid, 0);
        chk("rst_wvalid", bus.m_wvalid, 0);
        chk("rst_wlast", bus.m_wlast, 0);
        chk("rst_bready", bus.m_bready, 0);
        chk("rst_wr_slot", wr_slot, 0);
        chk("rst_bresp_err", bresp_err, 0);
        chk("rst_pulses", {burst_done, pkt_done}, 0);
        @(posedge clock);
        #1;
        rst = 1'b0;
        @(negedge clock);
        chk("tready_after_rst", bus.s_tready, 1);
        tick();

        // One full 16-beat packet
        a0 = aw_addr_q.size();
        w0 = w_data_q.size();
        p0 = pd_q.size();
        send_pkt(16, 0);
        @(negedge clock);
        chk("t1_aw_not_yet", bus.m_awvalid, 0);
        tick();
        @(negedge clock);
        chk("t1_aw_2cyc", bus.m_awvalid, 1);
        chk("t1_awsize", bus.m_awsize, 3'd4);
        chk("t1_awburst", bus.m_awburst, 2'b01);
        wait_bursts(p0 + 1);
        chk("t1_aw_count", aw_addr_q.size() - a0, 1);
        chk_aw("t1_aw0", a0, 0, 15);
        chk_data("t1", w0, 0, 16);
        chk("t1_wlast_pos", w_last_q[w0 + 15], 1);
        chk("t1_wlast_cnt", count_lasts(w0), 1);
        chk("t1_pkt_done", pd_q[p0], 1);
        chk("t1_wr_slot", wr_slot, 1);

        // 40-beat packet split 16/16/8
        do_reset(2);
        a0 = aw_addr_q.size();
        w0 = w_data_q.size();
        p0 = pd_q.size();
        chk("t2_slot_reset", wr_slot, 0);
        send_pkt(40, 100);
        wait_bursts(p0 + 3);
        chk("t2_aw_count", aw_addr_q.size() - a0, 3);
        chk_aw("t2_aw0", a0, 0, 15);
        chk_aw("t2_aw1", a0 + 1, 1, 15);
        chk_aw("t2_aw2", a0 + 2, 2, 7);
        chk_data("t2", w0, 100, 40);
        chk("t2_wlast_cnt", count_lasts(w0), 3);
        chk("t2_pd", {pd_q[p0], pd_q[p0 + 1], pd_q[p0 + 2]}, 3'b001);
        chk("t2_wr_slot", wr_slot, 3);

        // Three single-beat packets
        do_reset(2);
        a0 = aw_addr_q.size();
        w0 = w_data_q.size();
        p0 = pd_q.size();
        send_pkt(1, 200);
        send_pkt(1, 201);
        send_pkt(1, 202);
        wait_bursts(p0 + 3);
        chk("t3_aw_count", aw_addr_q.size() - a0, 3);
        chk_aw("t3_aw0", a0, 0, 0);
        chk_aw("t3_aw1", a0 + 1, 1, 0);
        chk_aw("t3_aw2", a0 + 2, 2, 0);
        chk_data("t3", w0, 200, 3);
        chk("t3_pd", {pd_q[p0], pd_q[p0 + 1], pd_q[p0 + 2]}, 3'b111);

        // Backpressure, FIFO fill, ring wrap, error response on burst 2
        do_reset(2);
        a0 = aw_addr_q.size();
        w0 = w_data_q.size();
        p0 = pd_q.size();
        err_burst = b_issued + 1;
        aw_hold = 1'b1;
        aw_delay = 5;
        w_toggle = 1'b1;
        acc = 0;
        bus.s_tvalid = 1'b1;
        for (int c = 0; c < 120; c++) begin
            bus.s_tdata = mk(300 + acc);
            bus.s_tlast = (acc % 16 == 15);
            @(negedge clock);
            if (bus.s_tready) acc++;
            tick();
        end
        @(negedge clock);
        chk("t4_fill_beats", acc, 64);
        chk("t4_tready_full", bus.s_tready, 0);
        chk("t4_no_aw_held", aw_addr_q.size() - a0, 0);
        tick();
        bus.s_tvalid = 1'b0;
        bus.s_tlast = 1'b0;
        aw_hold = 1'b0;
        send_pkt(16, 364);
        wait_bursts(p0 + 5);
        chk("t4_aw_count", aw_addr_q.size() - a0, 5);
        chk_aw("t4_aw0", a0, 0, 15);
        chk_aw("t4_aw1", a0 + 1, 1, 15);
        chk_aw("t4_aw3", a0 + 3, 3, 15);
        chk_aw("t4_aw4_wrap", a0 + 4, 0, 15);
        chk_data("t4", w0, 300, 80);
        chk("t4_pd", {pd_q[p0], pd_q[p0 + 1], pd_q[p0 + 2],
                      pd_q[p0 + 3], pd_q[p0 + 4]}, 5'b11111);
        chk("t4_bresp_err", bresp_err, 1);
        chk("t4_wr_slot", wr_slot, 1);
        err_burst = -1;
        aw_delay = 0;
        w_toggle = 1'b0;

        // Reset in the middle of a W phase
        w_stall = 1'b1;
        send_pkt(16, 500);
        acc = 0;
        while (!bus.m_wvalid && acc < 200) begin
            @(negedge clock);
            acc++;
        end
        chk("t5_in_w", bus.m_wvalid, 1);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clock);
        chk("t5_wvalid", bus.m_wvalid, 0);
        chk("t5_awvalid", bus.m_awvalid, 0);
        chk("t5_bready", bus.m_bready, 0);
        chk("t5_wr_slot", wr_slot, 0);
        chk("t5_bresp_err", bresp_err, 0);
        chk("t5_tready", bus.s_tready, 1);
        tick();
        w_stall = 1'b0;
        a0 = aw_addr_q.size();
        w0 = w_data_q.size();
        p0 = pd_q.size();
        send_pkt(3, 600);
        wait_bursts(p0 + 1);
        chk("t5_aw_count", aw_addr_q.size() - a0, 1);
        chk_aw("t5_aw0", a0, 0, 2);
        chk_data("t5", w0, 600, 3);
        chk("t5_pd", pd_q[p0], 1);
        chk("t5_wr_slot_after", wr_slot, 1);

        chk("no_w_before_aw", w_early, 0);
        chk("no_stray_pkt_done", stray_pd, 0);
        chk("no_timeouts", timeouts, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/udp_stream_ddr_writer.md
# udp_stream_ddr_writer

Consumes the UDP payload AXI-Stream from the Ethernet receive path and writes it into a DDR ring region through an AXI4 write master. It sits between the Ethernet UDP receive stream and the DDR DMA AXI4 interconnect port. It chops packets into bursts of at most `BURST_LEN` beats, one burst per fixed address slot, with one burst outstanding at a time.

## Interface
- `DSIZE`, 128: stream and AXI data width, bits (power of two, ≥32).
- `ASIZE`, 32: AXI address width.
- `IDSIZE`, 4: AXI ID width; `AWID` is constant 0.
- `BURST_LEN`, 16: max beats per burst (power of two, 2..256); slot size = `BURST_LEN*DSIZE/8` bytes, ≤4096.
- `BASE_ADDR`, 0: ring start, slot-aligned.
- `SLOTS`, 1024: ring length in slots (power of two).
- `SEG_DEPTH`, 4: segment queue depth; data FIFO depth = `SEG_DEPTH*BURST_LEN`.
- `clock` in 1: single clock, all logic rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `s_tdata` in DSIZE, `s_tvalid` in 1, `s_tlast` in 1, `s_tready` out 1: UDP payload slave stream.
- `m_awid` out IDSIZE, `m_awaddr` out ASIZE, `m_awlen` out 8, `m_awsize` out 3 (log2(DSIZE/8)), `m_awburst` out 2 (INCR=01), `m_awvalid` out 1, `m_awready` in 1.
- `m_wdata` out DSIZE, `m_wstrb` out DSIZE/8 (all ones), `m_wlast` out 1, `m_wvalid` out 1, `m_wready` in 1.
- `m_bid` in IDSIZE, `m_bresp` in 2, `m_bvalid` in 1, `m_bready` out 1.
- `burst_done` out 1: one-cycle pulse on B handshake.
- `pkt_done` out 1: one-cycle pulse on B handshake of a burst closing a packet.
- `wr_slot` out log2(SLOTS): slot index of the next burst to issue.
- `bresp_err` out 1: sticky, set by any `m_bresp != 0`, cleared only by `rst`.

## Operation
- Input segmenter: counts accepted beats; closes a segment at `s_tlast` or at beat `BURST_LEN`, whichever first; pushes {len, last} into the segment queue; counter restarts at 0.
- Data beats go into the data FIFO on every `s_tvalid && s_tready`.
- `s_tready` = data FIFO not full AND segment queue has room for a push this cycle.
- FSM: IDLE → AW when the segment queue is non-empty (pop it, latch len/last). AW: `m_awvalid`=1, `m_awaddr`=`BASE_ADDR + wr_slot*slot_size`, `m_awlen`=len−1; on `m_awready` → W. W: stream len beats from the FIFO, `m_wvalid` = FIFO non-empty, `m_wlast` on beat len; after the last handshake → B. B: `m_bready`=1; on `m_bvalid` → IDLE, pulse `burst_done` (plus `pkt_done` if last), `wr_slot` += 1 mod SLOTS.
- A partial burst still consumes a full slot, so bursts never cross a 4 KB boundary.
- `wr_slot` wraps SLOTS−1 → 0; no overrun protection against the consumer (system-level contract).
- `m_bid` is ignored. A `m_bresp` error sets `bresp_err`; the burst is not retried and the slot still advances.

## Timing
- Reset values: `s_tready`=0 during reset (1 the cycle after if space), all `*valid`=0, `m_bready`=0, `m_wlast`=0, pulses 0, `wr_slot`=0, `bresp_err`=0, FSM=IDLE, FIFO/queue empty, segment counter 0.
- Segment push is registered: `m_awvalid` rises 2 cycles after the closing input beat when the FSM is idle.
- AW is never issued before its segment is complete. W follows AW acceptance (no early W).
- Held `valid` outputs keep their payload stable until the handshake.
- Simultaneous segment push and pop on a full queue is allowed; `s_tready` is computed with pop awareness.
- B→IDLE→AW costs one idle cycle. Back-to-back bursts: ≥2 cycles between AW handshakes.
- `rst` mid-burst aborts immediately and flushes all state; `wr_slot` returns to 0.

## Structure
- Package `udp_ddr_pkg`: FSM state enum (IDLE, AW, W, B), segment record typedef {len[8:0], last}, `AXI_BURST_INCR`/`AXI_RESP_OKAY` constants.
- Sub-module `udp_ddr_sync_fifo`: parameterised single-clock FWFT FIFO (width, depth). Instantiated twice: data (DSIZE) and segment queue.

## Test plan
- 16-beat packet, BURST_LEN=16, ready always high → one AW at `BASE_ADDR`, awlen=15, wlast on beat 16, `pkt_done` pulse, `wr_slot`=1.
- 40-beat packet → three bursts, awlen 15/15/7, slots 0/1/2; `pkt_done` only on the third.
- 1-beat packets ×3 → three awlen=0 bursts at slot addresses 0, 256 B, 512 B (DSIZE=128); each pulses `pkt_done`.
- `m_wready` toggling 50% with `m_awready` delayed 5 cycles → data order intact, no W before AW, `s_tready` drops once FIFO holds 64 beats.
- SLOTS=4, 5 full bursts → the fifth uses slot 0 address; `m_bresp`=2 on burst 2 → `bresp_err` stays 1, slot still advances.
- `rst` asserted mid W phase → next cycle all valids 0, `wr_slot`=0; a new packet restarts cleanly at `BASE_ADDR`.
